// File: rtl/param_digit_timer_pkg.sv
// rtl/param_digit_timer_pkg.sv - shared constants and types for the BCD digit timer
// Purpose: FSM state encoding, BCD digit limit, default prescaler divide and the
//          start-value clamp helper used by param_digit_timer and bcd_digit_cell.
// Ports:   none (package).
package param_digit_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timerState_e;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam int         DEFAULT_TICK_DIV = 50_000_000;

  // Out-of-range BCD nibbles (A..F) saturate to the largest legal digit.
  function automatic logic [3:0] clampBcd(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit of the up/down timer chain
// Purpose: holds a single BCD digit; loads, or steps by one when enabled and the
//          lower digits ripple a borrow/carry into it.
// Ports:   clk, rst (sync active-low), loadEn/loadVal (parallel load),
//          stepEn (count edge), countUp (direction), carryIn/carryOut (ripple),
//          termVal (this digit's terminal value), digit (current value),
//          nextIsTerm (value after this step equals termVal).
module bcd_digit_cell
  import param_digit_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       loadEn,
  input  logic [3:0] loadVal,
  input  logic       stepEn,
  input  logic       countUp,
  input  logic       carryIn,
  input  logic [3:0] termVal,
  output logic [3:0] digit,
  output logic       carryOut,
  output logic       nextIsTerm
);

  logic [3:0] nextDigit;

  // carryIn doubles as borrowIn when counting down; digit 0 has it tied high.
  always_comb begin
    nextDigit = digit;
    carryOut  = 1'b0;
    if (carryIn) begin
      if (countUp) begin
        if (digit >= BCD_MAX) begin
          nextDigit = 4'd0;
          carryOut  = 1'b1;
        end else begin
          nextDigit = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          nextDigit = BCD_MAX;
          carryOut  = 1'b1;
        end else begin
          nextDigit = digit - 4'd1;
        end
      end
    end
    nextIsTerm = (nextDigit == termVal);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (loadEn) begin
      digit <= loadVal;
    end else if (stepEn) begin
      digit <= nextDigit;
    end
  end

endmodule

// File: rtl/param_digit_timer.sv
// rtl/param_digit_timer.sv - parameterised multi-digit BCD countdown/countup timer
// Purpose: prescaler produces one tick every TICK_DIV cycles while running; each
//          tick steps a NUM_DIGITS BCD counter down to 0 or up to the captured
//          start value, then the timer expires.
// Ports:   clk, rst (sync active-low), enable (run/pause), load (arm strobe),
//          start_val/mode (captured on load), digits (BCD count), tick,
//          running, time_out (expired level), expire_pulse (one cycle on expiry).
module param_digit_timer
  import param_digit_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = DEFAULT_TICK_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] start_val,
  input  logic                    mode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    running,
  output logic                    time_out,
  output logic                    expire_pulse
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  timerState_e             state;
  logic [PW-1:0]           prescaler;
  logic                    modeReg;
  logic [4*NUM_DIGITS-1:0] termReg;
  logic [4*NUM_DIGITS-1:0] clampedVal;
  logic [4*NUM_DIGITS-1:0] initVal;
  logic [NUM_DIGITS:0]     carry;
  logic [NUM_DIGITS-1:0]   digitTerm;
  logic                    stepEn;
  logic                    stepHitsTerm;
  logic                    loadIsTerm;

  always_comb begin
    clampedVal = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      clampedVal[4*i +: 4] = clampBcd(start_val[4*i +: 4]);
    end
  end

  assign initVal = mode ? '0 : clampedVal;
  // Down-count starts at start_val and ends at 0; up-count starts at 0 and ends
  // at start_val. Either way the load is already terminal iff start_val is 0.
  assign loadIsTerm   = (clampedVal == '0);
  assign tick         = (state == RUN) && (prescaler == PRE_LAST);
  assign stepEn       = tick && !load;   // a coincident load wins over the step
  assign stepHitsTerm = &digitTerm;
  assign running      = (state == RUN);
  assign time_out     = (state == EXPIRED);
  assign carry[0]     = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
    bcd_digit_cell uCell (
      .clk        (clk),
      .rst        (rst),
      .loadEn     (load),
      .loadVal    (initVal[4*g +: 4]),
      .stepEn     (stepEn),
      .countUp    (modeReg),
      .carryIn    (carry[g]),
      .termVal    (modeReg ? termReg[4*g +: 4] : 4'd0),
      .digit      (digits[4*g +: 4]),
      .carryOut   (carry[g+1]),
      .nextIsTerm (digitTerm[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      prescaler    <= '0;
      modeReg      <= 1'b0;
      termReg      <= '0;
      expire_pulse <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      if (load) begin
        modeReg   <= mode;
        termReg   <= clampedVal;
        prescaler <= '0;
        if (loadIsTerm) begin
          state        <= EXPIRED;
          expire_pulse <= 1'b1;
        end else begin
          state <= enable ? RUN : PAUSED;
        end
      end else begin
        case (state)
          RUN: begin
            // enable only decides the next state; the current cycle completes.
            if (tick) begin
              prescaler <= '0;
              if (stepHitsTerm) begin
                state        <= EXPIRED;
                expire_pulse <= 1'b1;
              end else begin
                state <= enable ? RUN : PAUSED;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
              state     <= enable ? RUN : PAUSED;
            end
          end
          PAUSED: begin
            if (enable) state <= RUN;
          end
          EXPIRED: begin
            prescaler <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_digit_timer.sv
// tb/tb_param_digit_timer.sv - directed self-checking bench for param_digit_timer
module tb_param_digit_timer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, load, mode;
  logic [7:0]  startVal, digits;
  logic        tick, running, timeOut, expirePulse;

  logic        enableB, loadB, modeB;
  logic [11:0] startValB, digitsB;
  logic        tickB, runningB, timeOutB, expirePulseB;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic        sawTick;

  param_digit_timer #(.NUM_DIGITS(2), .TICK_DIV(4)) uDut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .start_val(startVal),
    .mode(mode), .digits(digits), .tick(tick), .running(running),
    .time_out(timeOut), .expire_pulse(expirePulse)
  );

  param_digit_timer #(.NUM_DIGITS(3), .TICK_DIV(4)) uDutB (
    .clk(clk), .rst(rst), .enable(enableB), .load(loadB), .start_val(startValB),
    .mode(modeB), .digits(digitsB), .tick(tickB), .running(runningB),
    .time_out(timeOutB), .expire_pulse(expirePulseB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic doLoad(input logic [7:0] val, input logic m);
    startVal = val;
    mode     = m;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  // From a point just after a load/step edge: tick must appear 3 cycles later,
  // and the digits must move on the edge that closes that tick cycle.
  task automatic expectStep(input string tag, input logic [7:0] exp);
    step(3);
    check({tag, "_tick"}, tick, 1);
    step(1);
    check(tag, digits, exp);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; load = 1'b0; mode = 1'b0; startVal = '0;
    enableB = 1'b0; loadB = 1'b0; modeB = 1'b0; startValB = '0;
    step(2);
    check("rst_digits",  digits, 0);
    check("rst_running", running, 0);
    check("rst_timeout", timeOut, 0);
    check("rst_tick",    tick, 0);
    check("rst_expire",  expirePulse, 0);

    rst = 1'b1; enable = 1'b1;
    step(3);
    check("idle_digits",  digits, 0);
    check("idle_running", running, 0);

    // Count down 12 -> 00
    doLoad(8'h12, 1'b0);
    check("ld12_digits",  digits, 8'h12);
    check("ld12_running", running, 1);
    check("ld12_timeout", timeOut, 0);
    expectStep("dn11", 8'h11);
    expectStep("dn10", 8'h10);
    expectStep("dn09", 8'h09);
    for (int v = 8; v >= 1; v--) expectStep("dn", toBcd(v));
    expectStep("dn00", 8'h00);
    check("dn00_expire",  expirePulse, 1);
    check("dn00_timeout", timeOut, 1);
    check("dn00_running", running, 0);
    step(1);
    check("dn00_expire_once", expirePulse, 0);
    sawTick = 1'b0;
    repeat (20) begin
      step(1);
      if (tick) sawTick = 1'b1;
    end
    check("exp_quiet_tick", sawTick, 0);
    check("exp_hold_digits", digits, 8'h00);
    check("exp_hold_timeout", timeOut, 1);

    // Count up 00 -> 15; mode input flips mid-run and must be ignored
    doLoad(8'h15, 1'b1);
    mode = 1'b0;
    check("up_start", digits, 8'h00);
    check("up_timeout_clr", timeOut, 0);
    for (int v = 1; v <= 15; v++) expectStep("up", toBcd(v));
    check("up15_expire",  expirePulse, 1);
    check("up15_timeout", timeOut, 1);

    // Two-cycle pause in the middle of a prescale period
    doLoad(8'h50, 1'b0);
    step(1);
    enable = 1'b0;
    step(2);
    check("pause_running", running, 0);
    check("pause_tick",    tick, 0);
    enable = 1'b1;
    step(1);
    check("resume_running", running, 1);
    check("resume_notick",  tick, 0);
    step(1);
    check("resume_tick", tick, 1);
    step(1);
    check("pause_49", digits, 8'h49);

    // Load on the tick cycle wins: no step, prescaler restarts
    step(3);
    check("pre_tick", tick, 1);
    doLoad(8'h37, 1'b0);
    check("tickld_digits",  digits, 8'h37);
    check("tickld_expire",  expirePulse, 0);
    check("tickld_running", running, 1);
    expectStep("tickld_36", 8'h36);

    // Clamp and immediate expiry
    doLoad(8'hA3, 1'b0);
    check("clamp_93", digits, 8'h93);
    doLoad(8'h00, 1'b0);
    check("zero_digits",  digits, 8'h00);
    check("zero_expire",  expirePulse, 1);
    check("zero_timeout", timeOut, 1);
    check("zero_running", running, 0);
    step(1);
    check("zero_expire_once", expirePulse, 0);
    check("zero_timeout_hold", timeOut, 1);

    // Reset mid-count at 07
    doLoad(8'h08, 1'b0);
    expectStep("rs07", 8'h07);
    step(1);
    rst = 1'b0;
    step(1);
    check("rs_digits",  digits, 0);
    check("rs_running", running, 0);
    check("rs_timeout", timeOut, 0);
    check("rs_tick",    tick, 0);
    check("rs_expire",  expirePulse, 0);
    rst = 1'b1;
    sawTick = 1'b0;
    repeat (10) begin
      step(1);
      if (tick) sawTick = 1'b1;
    end
    check("rs_norestart_tick",    sawTick, 0);
    check("rs_norestart_running", running, 0);
    check("rs_norestart_digits",  digits, 0);

    // Three-digit instance: 100 -> 099 double borrow
    enableB   = 1'b1;
    startValB = 12'h100;
    loadB     = 1'b1;
    step(1);
    loadB     = 1'b0;
    check("b_load", digitsB, 12'h100);
    step(3);
    check("b_tick", tickB, 1);
    step(1);
    check("b_099", digitsB, 12'h099);
    check("b_running", runningB, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/param_digit_timer.md
PARAM_DIGIT_TIMER -- requirements
Module: param_digit_timer

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of BCD digits, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 50_000_000: clock cycles per count tick, minimum 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 enable  input  1  high = prescaler and count advance; low = hold (pause).
REQ-006 load  input  1  one-cycle strobe; captures start_val and mode, arms timer.
REQ-007 start_val  input  4*NUM_DIGITS  BCD terminal/start value; digit 0 in bits [3:0].
REQ-008 mode  input  1  0 = count down start_val->0; 1 = count up 0->start_val.
REQ-009 digits  output  4*NUM_DIGITS  current BCD count, same packing as start_val.
REQ-010 tick  output  1  one-cycle pulse per prescaler wrap while RUN.
REQ-011 running  output  1  high in RUN state.
REQ-012 time_out  output  1  level; high in EXPIRED until next load or reset.
REQ-013 expire_pulse  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSED, EXPIRED; reset enters IDLE.
REQ-015 load in any state SHALL move to RUN (PAUSED if enable low), set digits to start_val (mode 0) or all-zero (mode 1), clear prescaler, clear time_out.
REQ-016 Any start_val nibble >9 SHALL be captured as 9.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick asserts on the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-018 RUN->PAUSED when enable low; PAUSED->RUN when enable high; prescaler value SHALL be retained across pause.
REQ-019 Digits SHALL update on the clock edge ending the tick cycle: decrement (mode 0) or increment (mode 1) by one as a multi-digit BCD number with per-digit borrow/carry (0->9 borrow, 9->0 carry).
REQ-020 When the updated value equals the terminal value (0 in mode 0, captured start_val in mode 1) the FSM SHALL enter EXPIRED on that same edge; expire_pulse high for exactly that following cycle.
REQ-021 In EXPIRED digits SHALL freeze at terminal value, prescaler SHALL hold at 0, tick SHALL stay low.
REQ-022 load whose initial count already equals terminal SHALL enter EXPIRED directly with expire_pulse one cycle.
REQ-023 load coincident with tick SHALL win: reload applies, no count step, no expire_pulse.
REQ-024 enable low coincident with tick cycle: tick still completes that step (enable sampled for next cycle).
REQ-025 load with no prior load: IDLE ignores enable; digits hold 0, all pulses low.
REQ-026 mode and terminal value SHALL change only at load; mid-run mode changes ignored.

Reset
REQ-027 rst low at a clock edge SHALL force IDLE, digits=0, prescaler=0, tick=0, running=0, time_out=0, expire_pulse=0, overriding load.
REQ-028 Reset mid-count SHALL discard the captured start_val and mode.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, BCD_MAX (9) and default TICK_DIV constant.
REQ-030 One sub-module bcd_digit_cell SHALL implement a single digit: load value, step-enable, direction, borrow/carry in, borrow/carry out, terminal-digit flag; instantiated NUM_DIGITS times in a generate chain.
REQ-031 Prescaler and FSM SHALL reside in the top module; expected size 150-300 lines total.

Verification (NUM_DIGITS=2, TICK_DIV=4 unless stated)
REQ-032 load start_val=8'h12 mode 0, enable high -> digits 12,11,10,09 at 4-cycle spacing; 10->09 borrow correct.
REQ-033 Continue to 00 -> expire_pulse one cycle, time_out held, tick silent for 20 further cycles.
REQ-034 mode 1 start_val=8'h15 -> counts 00..15, 09->10 carry, expires at 15.
REQ-035 enable low 2 cycles mid-prescale -> next tick delayed exactly 2 cycles; load on tick cycle -> reload, no step.
REQ-036 start_val=8'hA3 -> captured 93; start_val=8'h00 mode 0 -> immediate EXPIRED, one expire_pulse.
REQ-037 rst low during RUN at count 07 -> all outputs 0, IDLE; enable alone does not restart; NUM_DIGITS=3 run 100->099.
